// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } div_state_e;

  localparam int unsigned DIV_ITERS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Architectural result for divide-by-zero, otherwise for signed overflow.
  function automatic logic [31:0] special_result(input logic        div_zero,
                                                 input logic        rem_sel,
                                                 input logic [31:0] dividend);
    if (div_zero) begin
      return rem_sel ? dividend : DIV_BY_ZERO_Q;
    end
    return rem_sel ? 32'h0 : INT_MIN;
  endfunction

endpackage

// File: rtl/div_iter_32_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface div_iter_32_if;

  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_unsigned;
  logic        i_rem;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  // Requester side (execute stage).
  modport master (
    output i_valid, i_dividend, i_divisor, i_unsigned, i_rem, i_ready,
    input  o_ready, o_valid, o_result
  );

  // Divider side.
  modport slave (
    input  i_valid, i_dividend, i_divisor, i_unsigned, i_rem, i_ready,
    output o_ready, o_valid, o_result
  );

endinterface

// File: rtl/add_pg_32.sv
// 32-bit adder with carry-in/carry-out and per-bit propagate/generate outputs.
module add_pg_32 (
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic [31:0] prop,
  output logic [31:0] gen
);

  // Sum, carry and bitwise propagate/generate terms.
  always_comb begin
    prop             = val1 ^ val2;
    gen              = val1 & val2;
    {carry_out, sum} = {1'b0, val1} + {1'b0, val2} + {32'h0, carry_in};
  end

endmodule

// File: rtl/div_iter_32.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to skip the iterations for divide-by-zero and signed overflow.
module div_iter_32
  import div_pkg::*;
(
  input logic          i_clk,
  input logic          i_rst_n,
  div_iter_32_if.slave bus
);

  localparam logic [4:0] LastIter = 5'(DIV_ITERS - 1);

  div_state_e  state_q, state_d;
  logic [31:0] dvd_q, dvs_q, quo_q, rem_q, result_q;
  logic [4:0]  cnt_q;
  logic        uns_q, rem_sel_q, quo_neg_q, rem_neg_q, div_zero_q, ovf_q;

  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag;
  logic        prep_div_zero, prep_ovf;
  logic [31:0] rem_shift, dvs_inv, trial_diff;
  logic        trial_carry, ge;
  logic [31:0] quo_fix, rem_fix, fix_result;

  // Operand magnitudes, special-case detection, iteration step and final sign fix-up.
  always_comb begin
    dvd_neg       = ~uns_q & dvd_q[31];
    dvs_neg       = ~uns_q & dvs_q[31];
    dvd_mag       = dvd_neg ? -dvd_q : dvd_q;
    dvs_mag       = dvs_neg ? -dvs_q : dvs_q;
    prep_div_zero = (dvs_q == 32'h0);
    prep_ovf      = ~uns_q && (dvd_q == INT_MIN) && (dvs_q == 32'hFFFF_FFFF);

    rem_shift     = {rem_q[30:0], quo_q[31]};
    dvs_inv       = ~dvs_q;
    // A bit shifted out of rem means it already exceeds any 32-bit divisor.
    ge            = rem_q[31] | trial_carry;

    quo_fix       = quo_neg_q ? -quo_q : quo_q;
    rem_fix       = rem_neg_q ? -rem_q : rem_q;
    if (div_zero_q || ovf_q) begin
      fix_result = special_result(div_zero_q, rem_sel_q, dvd_q);
    end else begin
      fix_result = rem_sel_q ? rem_fix : quo_fix;
    end
  end

  // Trial subtraction rem - div as rem + ~div + 1; carry-out set means no borrow.
  add_pg_32 u_trial_sub (
    .val1      (rem_shift),
    .val2      (dvs_inv),
    .carry_in  (1'b1),
    .sum       (trial_diff),
    .carry_out (trial_carry),
    .prop      (),
    .gen       ()
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.i_valid) state_d = StPrep;
      StPrep: begin
        state_d = StIter;
`ifdef DIV_EARLY_OUT_EN
        if (prep_div_zero || prep_ovf) state_d = StDone;
`endif
      end
      StIter: if (cnt_q == LastIter) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (bus.i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    bus.o_ready  = (state_q == StIdle);
    bus.o_valid  = (state_q == StDone);
    bus.o_result = result_q;
  end

  // Datapath registers: operand capture, magnitude load, shift/subtract, result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dvd_q      <= 32'h0;
      dvs_q      <= 32'h0;
      quo_q      <= 32'h0;
      rem_q      <= 32'h0;
      result_q   <= 32'h0;
      cnt_q      <= 5'h0;
      uns_q      <= 1'b0;
      rem_sel_q  <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            dvd_q     <= bus.i_dividend;
            dvs_q     <= bus.i_divisor;
            uns_q     <= bus.i_unsigned;
            rem_sel_q <= bus.i_rem;
          end
        end
        StPrep: begin
          // dvd_q keeps the original dividend for the divide-by-zero remainder.
          quo_q      <= dvd_mag;
          dvs_q      <= dvs_mag;
          rem_q      <= 32'h0;
          cnt_q      <= 5'h0;
          quo_neg_q  <= dvd_neg ^ dvs_neg;
          rem_neg_q  <= dvd_neg;
          div_zero_q <= prep_div_zero;
          ovf_q      <= prep_ovf;
`ifdef DIV_EARLY_OUT_EN
          if (prep_div_zero || prep_ovf) begin
            result_q <= special_result(prep_div_zero, rem_sel_q, dvd_q);
          end
`endif
        end
        StIter: begin
          rem_q <= ge ? trial_diff : rem_shift;
          quo_q <= {quo_q[30:0], ge};
          cnt_q <= cnt_q + 5'd1;
        end
        StFix:  result_q <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_32.sv
// Scoreboard bench for div_iter_32: the driver queues expected results, a monitor checks them.
module tb_div_iter_32;

  localparam int LatNorm = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int LatSpec = 1;
`else
  localparam int LatSpec = 34;
`endif

  typedef struct {
    string       name;
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  div_iter_32_if bus ();

  div_iter_32 dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Wait for o_ready, present one request, and queue its expected result after acceptance.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input logic rem, input logic [31:0] res, input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.o_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_accept actual=not_ready required=ready", name);
      return;
    end
    bus.i_valid    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    bus.i_unsigned = uns;
    bus.i_rem      = rem;
    @(posedge clk);
    #1;
    bus.i_valid    = 1'b0;
    bus.i_dividend = $urandom;
    bus.i_divisor  = $urandom;
    exp_q.push_back('{name: name, res: res, acc: cyc, lat: lat});
  endtask

  // Monitor: compare each new result and its latency, then check it holds while valid.
  initial begin
    logic [31:0] held;
    bit          seen;
    exp_t        e;
    seen = 1'b0;
    held = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          held = bus.o_result;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", bus.o_result);
          end else begin
            e = exp_q.pop_front();
            check(e.name, bus.o_result, e.res);
            check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
          end
        end else begin
          check("hold", bus.o_result, held);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b1;
    bus.i_dividend = 32'h0;
    bus.i_divisor  = 32'h0;
    bus.i_unsigned = 1'b0;
    bus.i_rem      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'h1);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_result", bus.o_result, 32'h0);
    rst_n = 1'b1;

    issue("divu_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, LatNorm);
    issue("remu_100_7", 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, LatNorm);
    issue("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFD, LatNorm);
    issue("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, LatNorm);
    issue("div_by0", 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, LatSpec);
    issue("divu_by0", 32'h1234_5678, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, LatSpec);
    issue("rem_by0", 32'h1234_5678, 32'h0, 1'b0, 1'b1, 32'h1234_5678, LatSpec);
    issue("remu_by0", 32'h1234_5678, 32'h0, 1'b1, 1'b1, 32'h1234_5678, LatSpec);
    issue("rem_neg_by0", 32'hFFFF_FFF9, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF9, LatSpec);
    issue("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, LatSpec);
    issue("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, LatSpec);
    issue("divu_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, LatNorm);
    issue("remu_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, LatNorm);
    issue("div_m20_m3", 32'hFFFF_FFEC, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd6, LatNorm);
    issue("rem_m20_m3", 32'hFFFF_FFEC, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFFE, LatNorm);
    issue("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, LatNorm);
    issue("remu_max_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, LatNorm);

    // Backpressure: hold the result, offer a bogus request that must be ignored.
    @(negedge clk);
    guard = 0;
    while (bus.o_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.i_ready = 1'b0;
    issue("bp_divu_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, LatNorm);
    guard = 0;
    while (bus.o_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp_valid_seen", 32'(bus.o_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      bus.i_valid    = 1'b1;
      bus.i_dividend = 32'h55;
      bus.i_divisor  = 32'd5;
      bus.i_unsigned = 1'b1;
      bus.i_rem      = 1'b0;
      @(negedge clk);
      check("bp_ready_low", 32'(bus.o_ready), 32'h0);
      check("bp_valid_high", 32'(bus.o_valid), 32'h1);
    end
    // Release with i_valid still high across the DONE->IDLE edge.
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(bus.o_ready), 32'h1);
    check("bp_idle_valid", 32'(bus.o_valid), 32'h0);
    bus.i_valid = 1'b0;
    issue("div_20_m3", 32'd20, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'hFFFF_FFFA, LatNorm);

    // Asynchronous reset in the middle of the iterations.
    issue("aborted", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, LatNorm);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(bus.o_valid), 32'h0);
    check("mid_rst_ready", 32'(bus.o_ready), 32'h1);
    check("mid_rst_result", bus.o_result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst_divu", 32'd1000, 32'd33, 1'b1, 1'b0, 32'd30, LatNorm);
    issue("post_rst_rem", 32'd20, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'd2, LatNorm);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
